// File: rtl/inst_word_assembler.sv
// Assembles NUM_BYTES sequential bus bytes into one instruction word.
// A gap in ena mid-word discards the partial word and pulses abort.

module inst_word_slot #(
  parameter int BYTE_W = 8
) (
  input  logic              clk1,
  input  logic              rst,
  input  logic              wr,
  input  logic              clr,
  input  logic [BYTE_W-1:0] d,
  output logic [BYTE_W-1:0] q
);
  always_ff @(posedge clk1) begin
    if (rst || clr) q <= '0;
    else if (wr)    q <= d;
  end
endmodule

module inst_word_assembler #(
  parameter int BYTE_W    = 8,
  parameter int NUM_BYTES = 2,
  parameter int MSB_FIRST = 1
) (
  input  logic                          clk1,
  input  logic                          rst,
  input  logic                          ena,
  input  logic [BYTE_W-1:0]             data,
  output logic [BYTE_W*NUM_BYTES-1:0]   opc_iraddr,
  output logic                          valid,
  output logic                          busy,
  output logic                          abort
);
  localparam int IW = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;

  logic [IW-1:0]                         idx;
  logic                                  last;
  logic                                  drop;
  logic [NUM_BYTES-1:0]                  sel;
  logic [NUM_BYTES-1:0][BYTE_W-1:0]      asm_q;
  logic [NUM_BYTES-1:0][BYTE_W-1:0]      word;

  assign last = (idx == IW'(NUM_BYTES-1));
  assign drop = !ena && (idx != '0);
  assign busy = (idx != '0);

  // Position p of the packed word holds the byte accepted at index K.
  for (genvar p = 0; p < NUM_BYTES; p++) begin : g_slot
    localparam int K = (MSB_FIRST != 0) ? (NUM_BYTES-1-p) : p;
    assign sel[p]  = (idx == IW'(K));
    assign word[p] = sel[p] ? data : asm_q[p];
    inst_word_slot #(.BYTE_W(BYTE_W)) u_slot (
      .clk1 (clk1),
      .rst  (rst),
      .wr   (ena & sel[p]),
      .clr  (drop),
      .d    (data),
      .q    (asm_q[p])
    );
  end

  always_ff @(posedge clk1) begin
    if (rst) begin
      idx        <= '0;
      opc_iraddr <= '0;
      valid      <= 1'b0;
      abort      <= 1'b0;
    end else begin
      valid <= ena && last;
      abort <= drop;
      if (ena) begin
        idx <= last ? '0 : idx + 1'b1;
        if (last) opc_iraddr <= word;
      end else begin
        idx <= '0;
      end
    end
  end
endmodule

// File: doc/inst_word_assembler.md
INST_WORD_ASSEMBLER -- requirements
Module: inst_word_assembler

Interface
REQ-001 The block SHALL have parameter BYTE_W, default 8, width in bits of one fetched byte (legal: >=1).
REQ-002 The block SHALL have parameter NUM_BYTES, default 2, bytes per instruction word (legal: 1..16).
REQ-003 The block SHALL have parameter MSB_FIRST, default 1, byte order: 1 = first byte lands in most-significant slot, 0 = first byte lands in least-significant slot.
REQ-004 The block SHALL have port clk1, input, 1 bit, sole clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit, synchronous active-high reset.
REQ-006 The block SHALL have port ena, input, 1 bit, byte-valid: data is accepted on every rising clk1 edge where ena=1.
REQ-007 The block SHALL have port data, input, BYTE_W bits, byte from memory bus.
REQ-008 The block SHALL have port opc_iraddr, output, BYTE_W*NUM_BYTES bits, last completed instruction word (registered).
REQ-009 The block SHALL have port valid, output, 1 bit, one-cycle pulse: opc_iraddr updated with a new complete word this cycle.
REQ-010 The block SHALL have port busy, output, 1 bit, high while a partially assembled word is held (byte index != 0).
REQ-011 The block SHALL have port abort, output, 1 bit, one-cycle pulse: a partial word was discarded.

Function
REQ-012 Internal state SHALL be a byte index idx (width max(1,clog2(NUM_BYTES))), range 0..NUM_BYTES-1, and an assembly register asm of BYTE_W*NUM_BYTES bits.
REQ-013 Slot k (k = idx at acceptance) SHALL be bits [BYTE_W*(NUM_BYTES-k)-1 : BYTE_W*(NUM_BYTES-k-1)] when MSB_FIRST=1, bits [BYTE_W*(k+1)-1 : BYTE_W*k] when MSB_FIRST=0.
REQ-014 ena=1, idx<NUM_BYTES-1: data SHALL be written to slot idx of asm, idx SHALL increment, opc_iraddr unchanged, valid=0 next cycle.
REQ-015 ena=1, idx=NUM_BYTES-1: opc_iraddr SHALL load asm with data merged into slot idx in the same edge, valid SHALL be 1 for exactly the following cycle, idx SHALL return to 0.
REQ-016 Latency: opc_iraddr and valid SHALL update on the edge that accepts the final byte; no additional pipeline stage.
REQ-017 Back-to-back words SHALL be accepted with no idle cycle; ena held high for 2*NUM_BYTES cycles SHALL yield two valid pulses NUM_BYTES cycles apart.
REQ-018 ena=0 with idx!=0: idx SHALL return to 0, asm contents SHALL be discarded, abort SHALL pulse one cycle, opc_iraddr SHALL keep its previous complete word.
REQ-019 ena=0 with idx=0: no state change; abort=0, valid=0.
REQ-020 opc_iraddr SHALL never expose a partially assembled word; it changes only on completion or reset.
REQ-021 Unused slots of asm after an abort SHALL not leak into the next word: every slot SHALL be rewritten before the next completion.
REQ-022 NUM_BYTES=1: every ena=1 cycle SHALL load opc_iraddr directly from data and pulse valid; busy and abort SHALL stay 0.
REQ-023 busy SHALL equal (idx!=0) as a registered-state decode; valid and abort SHALL never be high in the same cycle.

Reset
REQ-024 rst=1 SHALL take priority over ena: opc_iraddr=0, asm=0, idx=0, valid=0, busy=0, abort=0 after the edge.
REQ-025 rst asserted mid-word SHALL discard the partial word without an abort pulse.
REQ-026 No X values SHALL be produced on any output for any legal input sequence after first reset.

Verification
REQ-027 Defaults, ena=1 with data 0x12 then 0x34 -> after 2nd edge opc_iraddr=0x1234, valid=1 one cycle, busy 1 then 0.
REQ-028 MSB_FIRST=0, ena=1 with 0x12,0x34 -> opc_iraddr=0x3412.
REQ-029 Defaults, ena=1 0xAB, ena=0, ena=1 0xCD,0xEF -> abort pulse after the ena=0 edge, opc_iraddr unchanged until 0xCDEF, one valid pulse.
REQ-030 NUM_BYTES=4, ena held 8 cycles with 0x01..0x08 -> opc_iraddr 0x01020304 then 0x05060708, valid pulses 4 cycles apart.
REQ-031 Defaults, load 0x1234, then 0x56 and rst=1 next cycle -> all outputs 0, no abort; following 0x9A,0xBC -> 0x9ABC.
REQ-032 NUM_BYTES=1, BYTE_W=16, ena pulses 0xBEEF,0xCAFE -> valid each accepted cycle, opc_iraddr follows, busy=0 throughout.
